// File: rtl/alu_result_stage.sv
// Result stage behind the 64-bit ALU: registers result/destination with a valid/ready
// handshake, owns the NZCV flags and evaluates condition codes. Define SKID_BUF_EN for a two-entry skid buffer.
module alu_result_stage #(
  parameter int WIDTH      = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  input  logic                  alu_overflow,
  input  logic                  alu_carry_out,
  input  logic                  in_setflags,
  input  logic [3:0]            in_cond,
  input  logic [REG_ADDR_W-1:0] in_dest,
  input  logic                  in_regwrite,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_result,
  output logic [REG_ADDR_W-1:0] out_dest,
  output logic                  out_regwrite,
  output logic                  out_cond_true,
  output logic [3:0]            flags_q
);

  // Flags are ordered {N,Z,C,V}; 4'b1111 is an unconditional alias of AL.
  function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] flags);
    logic n;
    logic z;
    logic c;
    logic v;
    logic pass;
    n = flags[3];
    z = flags[2];
    c = flags[1];
    v = flags[0];
    case (cond)
      4'b0000: pass = z;
      4'b0001: pass = !z;
      4'b0010: pass = c;
      4'b0011: pass = !c;
      4'b0100: pass = n;
      4'b0101: pass = !n;
      4'b0110: pass = v;
      4'b0111: pass = !v;
      4'b1000: pass = c && !z;
      4'b1001: pass = !(c && !z);
      4'b1010: pass = (n == v);
      4'b1011: pass = (n != v);
      4'b1100: pass = !z && (n == v);
      4'b1101: pass = !(!z && (n == v));
      default: pass = 1'b1;
    endcase
    return pass;
  endfunction

  logic accept;
  logic send;
  logic entry_cond;

  assign accept     = in_valid && in_ready;
  assign send       = out_valid && out_ready;
  assign entry_cond = cond_pass(in_cond, flags_q);

  // Flags change at acceptance, so a stalled output never delays the next entry's condition.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= 4'b0000;
    end else if (accept && in_setflags) begin
      flags_q <= {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    end
  end

`ifdef SKID_BUF_EN
  logic                  skid_valid;
  logic [WIDTH-1:0]      skid_result;
  logic [REG_ADDR_W-1:0] skid_dest;
  logic                  skid_regwrite;
  logic                  skid_cond_true;

  assign in_ready = !skid_valid;

  // Skid only fills while main is held; it refills main on the edge main drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_dest       <= '0;
      out_regwrite   <= 1'b0;
      out_cond_true  <= 1'b0;
      skid_valid     <= 1'b0;
      skid_result    <= '0;
      skid_dest      <= '0;
      skid_regwrite  <= 1'b0;
      skid_cond_true <= 1'b0;
    end else if (skid_valid) begin
      if (send) begin
        out_result    <= skid_result;
        out_dest      <= skid_dest;
        out_regwrite  <= skid_regwrite;
        out_cond_true <= skid_cond_true;
        skid_valid    <= 1'b0;
      end
    end else if (accept) begin
      if (out_valid && !out_ready) begin
        skid_valid     <= 1'b1;
        skid_result    <= alu_result;
        skid_dest      <= in_dest;
        skid_regwrite  <= in_regwrite;
        skid_cond_true <= entry_cond;
      end else begin
        out_valid     <= 1'b1;
        out_result    <= alu_result;
        out_dest      <= in_dest;
        out_regwrite  <= in_regwrite;
        out_cond_true <= entry_cond;
      end
    end else if (send) begin
      out_valid <= 1'b0;
    end
  end
`else
  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_dest      <= '0;
      out_regwrite  <= 1'b0;
      out_cond_true <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_result    <= alu_result;
      out_dest      <= in_dest;
      out_regwrite  <= in_regwrite;
      out_cond_true <= entry_cond;
    end else if (send) begin
      out_valid <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed plan steps followed by random traffic
// compared against a queue-based model of the stage.
module tb_alu_result_stage;
  localparam int WIDTH      = 64;
  localparam int REG_ADDR_W = 5;
`ifdef SKID_BUF_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      alu_result;
  logic                  alu_negative;
  logic                  alu_zero;
  logic                  alu_overflow;
  logic                  alu_carry_out;
  logic                  in_setflags;
  logic [3:0]            in_cond;
  logic [REG_ADDR_W-1:0] in_dest;
  logic                  in_regwrite;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_result;
  logic [REG_ADDR_W-1:0] out_dest;
  logic                  out_regwrite;
  logic                  out_cond_true;
  logic [3:0]            flags_q;

  alu_result_stage #(.WIDTH(WIDTH), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .alu_negative(alu_negative), .alu_zero(alu_zero),
    .alu_overflow(alu_overflow), .alu_carry_out(alu_carry_out),
    .in_setflags(in_setflags), .in_cond(in_cond), .in_dest(in_dest),
    .in_regwrite(in_regwrite), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_dest(out_dest), .out_regwrite(out_regwrite),
    .out_cond_true(out_cond_true), .flags_q(flags_q)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0]      result;
    logic [REG_ADDR_W-1:0] dest;
    logic                  regwrite;
    logic                  cond_true;
  } entry_t;

  entry_t     model_q[$];
  logic [3:0] model_flags;
  bit         last_accept;
  int         total = 0;
  int         bad = 0;
  logic [WIDTH-1:0] seen[$];
  int         k;

  // Condition codes come in pairs: the odd code of each pair is the inverse of the even one.
  function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v, base;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cf;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cf && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: return 1'b1;
    endcase
    return c[0] ? !base : base;
  endfunction

  function automatic bit exp_ready();
    if (CAP == 2) return model_q.size() < 2;
    return (model_q.size() == 0) || out_ready;
  endfunction

  task automatic checkValue(input string name, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", name, observed, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("out_valid", 64'(out_valid), 64'(model_q.size() > 0));
    checkValue("in_ready", 64'(in_ready), 64'(exp_ready()));
    checkValue("flags_q", 64'(flags_q), 64'(model_flags));
    if (model_q.size() > 0) begin
      checkValue("out_result", out_result, model_q[0].result);
      checkValue("out_dest", 64'(out_dest), 64'(model_q[0].dest));
      checkValue("out_regwrite", 64'(out_regwrite), 64'(model_q[0].regwrite));
      checkValue("out_cond_true", 64'(out_cond_true), 64'(model_q[0].cond_true));
    end
  endtask

  task automatic applyStimulus(input bit valid, input logic [WIDTH-1:0] result, input logic [3:0] nzcv,
                               input bit setflags, input logic [3:0] cond,
                               input logic [REG_ADDR_W-1:0] dest, input bit regwrite, input bit ready);
    in_valid      = valid;
    alu_result    = result;
    alu_negative  = nzcv[3];
    alu_zero      = nzcv[2];
    alu_carry_out = nzcv[1];
    alu_overflow  = nzcv[0];
    in_setflags   = setflags;
    in_cond       = cond;
    in_dest       = dest;
    in_regwrite   = regwrite;
    out_ready     = ready;
  endtask

  // Model update for one rising edge, using the inputs as they stand at that edge.
  task automatic modelEdge();
    bit     send, acc;
    entry_t e;
    send = (model_q.size() > 0) && out_ready;
    acc  = in_valid && exp_ready();
    last_accept = 1'b0;
    if (reset) begin
      model_q.delete();
      model_flags = 4'b0000;
      return;
    end
    e.result    = alu_result;
    e.dest      = in_dest;
    e.regwrite  = in_regwrite;
    e.cond_true = ref_cond(in_cond, model_flags);
    if (send) void'(model_q.pop_front());
    if (acc) begin
      model_q.push_back(e);
      last_accept = 1'b1;
      if (in_setflags) model_flags = {alu_negative, alu_zero, alu_carry_out, alu_overflow};
    end
  endtask

  task automatic sampleEdge();
    @(negedge clk);
    if (!reset) checkOutput();
  endtask

  task automatic commitEdge();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic cycle();
    sampleEdge();
    commitEdge();
  endtask

  initial begin
    model_flags = 4'b0000;
    reset = 1'b1;
    applyStimulus(0, '0, 4'b0000, 0, 4'b1110, '0, 0, 1);
    cycle();
    cycle();
    reset = 1'b0;

    @(negedge clk);
    checkOutput();
    checkValue("rst_out_valid", 64'(out_valid), 64'd0);
    checkValue("rst_flags", 64'(flags_q), 64'd0);
    checkValue("rst_in_ready", 64'(in_ready), 64'd1);
    checkValue("rst_out_result", out_result, 64'd0);
    checkValue("rst_out_dest", 64'(out_dest), 64'd0);
    checkValue("rst_out_cond", 64'(out_cond_true), 64'd0);
    commitEdge();

    $display("[TB] basic transfer");
    applyStimulus(1, 64'h2, 4'b0000, 1, 4'b1110, 5'd3, 1, 1);
    cycle();
    applyStimulus(0, '0, 4'b0000, 0, 4'b1110, '0, 0, 1);
    sampleEdge();
    checkValue("basic_valid", 64'(out_valid), 64'd1);
    checkValue("basic_result", out_result, 64'h2);
    checkValue("basic_dest", 64'(out_dest), 64'd3);
    checkValue("basic_cond", 64'(out_cond_true), 64'd1);
    checkValue("basic_flags", 64'(flags_q), 64'd0);
    commitEdge();

    $display("[TB] flag ordering");
    applyStimulus(1, 64'hA, 4'b0100, 1, 4'b0000, 5'd1, 1, 1);
    cycle();
    applyStimulus(1, 64'hB, 4'b0000, 0, 4'b0000, 5'd2, 1, 1);
    sampleEdge();
    checkValue("order_a_eq", 64'(out_cond_true), 64'd0);
    commitEdge();
    applyStimulus(1, 64'hC, 4'b0000, 0, 4'b0001, 5'd3, 1, 1);
    sampleEdge();
    checkValue("order_b_eq", 64'(out_cond_true), 64'd1);
    commitEdge();
    applyStimulus(0, '0, 4'b0000, 0, 4'b1110, '0, 0, 1);
    sampleEdge();
    checkValue("order_c_ne", 64'(out_cond_true), 64'd0);
    commitEdge();

    $display("[TB] signed compares");
    applyStimulus(1, 64'hD, 4'b1000, 1, 4'b1110, 5'd4, 1, 1);
    cycle();
    applyStimulus(1, 64'hE, 4'b0000, 0, 4'b1011, 5'd5, 1, 1);
    cycle();
    applyStimulus(1, 64'hF, 4'b0000, 0, 4'b1100, 5'd6, 1, 1);
    sampleEdge();
    checkValue("signed_lt", 64'(out_cond_true), 64'd1);
    commitEdge();
    applyStimulus(1, 64'h10, 4'b1001, 1, 4'b1110, 5'd7, 0, 1);
    sampleEdge();
    checkValue("signed_gt", 64'(out_cond_true), 64'd0);
    commitEdge();
    applyStimulus(1, 64'h11, 4'b0000, 0, 4'b1010, 5'd8, 1, 1);
    cycle();
    applyStimulus(0, '0, 4'b0000, 0, 4'b1110, '0, 0, 1);
    sampleEdge();
    checkValue("signed_ge", 64'(out_cond_true), 64'd1);
    commitEdge();

    $display("[TB] backpressure");
    k = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(k < 3, 64'(10 + k), 4'b0000, 0, 4'b1110, 5'(10 + k), 1, 0);
      sampleEdge();
      if (i >= 1) checkValue("bp_hold", out_result, 64'd10);
      commitEdge();
      if (last_accept) k++;
    end
    seen.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(k < 3, 64'(10 + k), 4'b0000, 0, 4'b1110, 5'(10 + k), 1, 1);
      sampleEdge();
      if (out_valid) seen.push_back(out_result);
      commitEdge();
      if (last_accept) k++;
    end
    checkValue("bp_count", 64'(seen.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < seen.size()) checkValue("bp_order", seen[i], 64'(10 + i));
    end

    $display("[TB] reset with buffered entries");
    applyStimulus(1, 64'd20, 4'b0110, 1, 4'b1110, 5'd20, 1, 0);
    cycle();
    applyStimulus(1, 64'd21, 4'b0000, 0, 4'b1110, 5'd21, 1, 0);
    cycle();
    applyStimulus(0, '0, 4'b0000, 0, 4'b1110, '0, 0, 0);
    sampleEdge();
    checkValue("pre_rst_flags", 64'(flags_q), 64'h6);
    reset = 1'b1;
    commitEdge();
    reset = 1'b0;
    applyStimulus(0, '0, 4'b0000, 0, 4'b1110, '0, 0, 1);
    sampleEdge();
    checkValue("mid_rst_valid", 64'(out_valid), 64'd0);
    checkValue("mid_rst_flags", 64'(flags_q), 64'd0);
    commitEdge();
    for (int i = 0; i < 3; i++) begin
      sampleEdge();
      checkValue("post_rst_valid", 64'(out_valid), 64'd0);
      commitEdge();
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 9) < 7, {$urandom, $urandom}, 4'($urandom),
                    $urandom_range(0, 1) == 1, 4'($urandom), 5'($urandom),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 6);
      cycle();
    end
    reset = 1'b0;
    applyStimulus(0, '0, 4'b0000, 0, 4'b1110, '0, 0, 1);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
